// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution window scheduler.
package conv_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // 3x3 window at the default pixel width; [0][0] is the oldest row, leftmost pixel.
  typedef logic [0:2][0:2][DEFAULT_DATA_WIDTH-1:0] window_t;

  // Width that holds 9 * (2^dw - 1)^2 without truncation.
  function automatic int unsigned res_width(input int unsigned dw);
    return 2 * dw + 4;
  endfunction

endpackage

// File: rtl/conv3_window_scheduler_if.sv
// Pixel-in and result-out handshake bundle of the window scheduler.
interface conv3_window_scheduler_if
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
);

  localparam int unsigned RW = res_width(DATA_WIDTH);

  logic                  i_pix_valid;
  logic [DATA_WIDTH-1:0] i_pix_data;
  logic                  o_pix_ready;
  logic                  o_res_valid;
  logic [RW-1:0]         o_res_data;
  logic                  i_res_ready;

  modport master (
    output i_pix_valid, i_pix_data, i_res_ready,
    input  o_pix_ready, o_res_valid, o_res_data
  );

  modport slave (
    input  i_pix_valid, i_pix_data, i_res_ready,
    output o_pix_ready, o_res_valid, o_res_data
  );

endinterface

// File: rtl/conv_res_fifo.sv
// Synchronous result FIFO with occupancy count; head reads as zero when empty.
module conv_res_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CNTW-1:0]  cnt_q;
  logic             do_push, do_pop;

  // Qualify requests against occupancy and expose head/status.
  always_comb begin
    o_empty = (cnt_q == '0);
    do_push = i_push && (cnt_q != CNT_FULL);
    do_pop  = i_pop && !o_empty;
    o_data  = o_empty ? '0 : mem[rd_q];
    o_count = cnt_q;
  end

  // Pointer and count update; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_q] <= i_data;
  end

endmodule

// File: rtl/conv3_window_scheduler.sv
// Builds 3x3 windows from a raster pixel stream, feeds a fixed-latency
// convolution core and returns results through a credit-protected FIFO.
module conv3_window_scheduler
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned IMG_W        = 8,
  parameter int unsigned IMG_H        = 8,
  parameter int unsigned CONV_LATENCY = 2,
  parameter int unsigned RES_DEPTH    = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_start,
  input  logic [0:2][0:2][DATA_WIDTH-1:0]    i_kernel,
  output logic                               o_busy,
  output logic                               o_done,
  conv3_window_scheduler_if.slave            bus,
  output logic [0:2][0:2][DATA_WIDTH-1:0]    o_conv_data,
  output logic [0:2][0:2][DATA_WIDTH-1:0]    o_conv_kernel,
  input  logic [res_width(DATA_WIDTH)-1:0]   i_conv_result
);

  localparam int unsigned RW  = res_width(DATA_WIDTH);
  localparam int unsigned XW  = $clog2(IMG_W);
  localparam int unsigned YW  = $clog2(IMG_H);
  localparam int unsigned FCW = $clog2(RES_DEPTH + 1);
  localparam int unsigned CW  = $clog2(RES_DEPTH + CONV_LATENCY + 2) + 1;
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_ISSUE = XW'(2);
  localparam logic [YW-1:0] Y_ISSUE = YW'(2);
  localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);

  state_t state_q, state_d;

  logic [XW-1:0]                    x_q;
  logic [YW-1:0]                    y_q;
  logic [0:2][0:2][DATA_WIDTH-1:0]  win_q;
  logic [0:2][0:2][DATA_WIDTH-1:0]  kernel_q;
  logic [DATA_WIDTH-1:0]            lb0 [IMG_W];
  logic [DATA_WIDTH-1:0]            lb1 [IMG_W];
  logic                             issue_q;
  logic [CONV_LATENCY-1:0]          pipe_q;
  logic [FCW-1:0]                   fifo_count;
  logic                             fifo_empty;
  logic [CW-1:0]                    occupancy;
  logic                             pix_ready, pix_acc, last_pix, issue_now;
  logic                             start_acc, push, pop;

  // Credit check: FIFO entries plus windows still travelling through the core.
  always_comb begin
    occupancy = CW'(fifo_count) + CW'(issue_q);
    for (int unsigned i = 0; i < CONV_LATENCY; i++) begin
      occupancy = occupancy + CW'(pipe_q[i]);
    end
    pix_ready = (state_q == STREAM) && (occupancy < DEPTH_C);
    pix_acc   = bus.i_pix_valid && pix_ready;
    last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
    issue_now = pix_acc && (x_q >= X_ISSUE) && (y_q >= Y_ISSUE);
    push      = pipe_q[CONV_LATENCY-1];
    pop       = !fifo_empty && bus.i_res_ready;
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = STREAM;
          start_acc = 1'b1;
        end
      end
      STREAM:  if (pix_acc && last_pix) state_d = DRAIN;
      DRAIN:   if (!issue_q && (pipe_q == '0) && fifo_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Raster counters, window shift, kernel latch and issue pipe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      win_q    <= '0;
      kernel_q <= '0;
      issue_q  <= 1'b0;
      pipe_q   <= '0;
    end else begin
      if (start_acc) begin
        kernel_q <= i_kernel;
        x_q      <= '0;
        y_q      <= '0;
      end
      issue_q   <= issue_now;
      pipe_q[0] <= issue_q;
      for (int unsigned i = 1; i < CONV_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      if (pix_acc) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1[x_q];
        win_q[1][2] <= lb0[x_q];
        win_q[2][2] <= bus.i_pix_data;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  // Line buffers: row y-2 in lb1, row y-1 in lb0, addressed by column.
  always_ff @(posedge i_clk) begin
    if (pix_acc) begin
      lb1[x_q] <= lb0[x_q];
      lb0[x_q] <= bus.i_pix_data;
    end
  end

  conv_res_fifo #(
    .WIDTH (RW),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (i_conv_result),
    .i_pop   (pop),
    .o_data  (bus.o_res_data),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // Output drive.
  always_comb begin
    o_busy          = (state_q != IDLE);
    o_done          = (state_q == DONE);
    bus.o_pix_ready = pix_ready;
    bus.o_res_valid = !fifo_empty;
    o_conv_data     = win_q;
    o_conv_kernel   = kernel_q;
  end

endmodule

// File: tb/tb_conv3_window_scheduler.sv
// Scoreboard bench: 4x4, 8x8 and 5x3 scheduler instances sharing one driver.
module tb_conv3_window_scheduler;
  import conv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          sel;
  logic        start;
  window_t     kernel;
  logic        pix_valid;
  logic [3:0]  pix_data;
  logic        res_ready;
  int          res_mode;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int pop_count = 0;
  int frame_n = 0;
  window_t k_saved;
  logic [11:0] exp_q [$];
  logic [3:0]  img [64];

  conv3_window_scheduler_if #(.DATA_WIDTH(4)) bus_a ();
  conv3_window_scheduler_if #(.DATA_WIDTH(4)) bus_b ();
  conv3_window_scheduler_if #(.DATA_WIDTH(4)) bus_c ();

  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  window_t cd_a, cd_b, cd_c, ck_a, ck_b, ck_c;
  logic [11:0] s1_a, s1_b, s1_c, cr_a, cr_b, cr_c;

  assign bus_a.i_pix_valid = (sel == 0) && pix_valid;
  assign bus_b.i_pix_valid = (sel == 1) && pix_valid;
  assign bus_c.i_pix_valid = (sel == 2) && pix_valid;
  assign bus_a.i_pix_data  = pix_data;
  assign bus_b.i_pix_data  = pix_data;
  assign bus_c.i_pix_data  = pix_data;
  assign bus_a.i_res_ready = (sel == 0) && res_ready;
  assign bus_b.i_res_ready = (sel == 1) && res_ready;
  assign bus_c.i_res_ready = (sel == 2) && res_ready;

  conv3_window_scheduler #(.DATA_WIDTH(4), .IMG_W(4), .IMG_H(4), .CONV_LATENCY(2), .RES_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start((sel == 0) && start), .i_kernel(kernel),
    .o_busy(busy_a), .o_done(done_a), .bus(bus_a),
    .o_conv_data(cd_a), .o_conv_kernel(ck_a), .i_conv_result(cr_a));
  conv3_window_scheduler #(.DATA_WIDTH(4), .IMG_W(8), .IMG_H(8), .CONV_LATENCY(2), .RES_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start((sel == 1) && start), .i_kernel(kernel),
    .o_busy(busy_b), .o_done(done_b), .bus(bus_b),
    .o_conv_data(cd_b), .o_conv_kernel(ck_b), .i_conv_result(cr_b));
  conv3_window_scheduler #(.DATA_WIDTH(4), .IMG_W(5), .IMG_H(3), .CONV_LATENCY(2), .RES_DEPTH(4)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start((sel == 2) && start), .i_kernel(kernel),
    .o_busy(busy_c), .o_done(done_c), .bus(bus_c),
    .o_conv_data(cd_c), .o_conv_kernel(ck_c), .i_conv_result(cr_c));

  // Stand-in for the external core: multiply-accumulate, two registered stages.
  function automatic logic [11:0] mac(input window_t w, input window_t k);
    logic [11:0] acc = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc = acc + 12'(w[r][c]) * 12'(k[r][c]);
    return acc;
  endfunction

  always_ff @(posedge clk) begin
    s1_a <= mac(cd_a, ck_a); cr_a <= s1_a;
    s1_b <= mac(cd_b, ck_b); cr_b <= s1_b;
    s1_c <= mac(cd_c, ck_c); cr_c <= s1_c;
  end

  logic sel_pix_ready, sel_res_valid, sel_busy, sel_done;
  logic [11:0] sel_res_data;
  window_t sel_cd, sel_ck;

  always_comb begin
    sel_pix_ready = bus_a.o_pix_ready; sel_res_valid = bus_a.o_res_valid;
    sel_res_data = bus_a.o_res_data; sel_busy = busy_a; sel_done = done_a;
    sel_cd = cd_a; sel_ck = ck_a;
    case (sel)
      1: begin
        sel_pix_ready = bus_b.o_pix_ready; sel_res_valid = bus_b.o_res_valid;
        sel_res_data = bus_b.o_res_data; sel_busy = busy_b; sel_done = done_b;
        sel_cd = cd_b; sel_ck = ck_b;
      end
      2: begin
        sel_pix_ready = bus_c.o_pix_ready; sel_res_valid = bus_c.o_res_valid;
        sel_res_data = bus_c.o_res_data; sel_busy = busy_c; sel_done = done_c;
        sel_cd = cd_c; sel_ck = ck_c;
      end
      default: ;
    endcase
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer-ready driver: 0 = always ready, 1 = held off, 2 = random.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (res_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'b0;
        default: res_ready = ($urandom_range(99) < 60);
      endcase
    end
  end

  // Monitor: pop the scoreboard on every accepted result; watch for pushes into a full FIFO.
  initial forever begin
    @(negedge clk);
    if (rst_n && sel_res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got %0d required none", sel_res_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if (sel_res_data !== e) begin
          errors++;
          $display("FAIL result_%0d got %0d required %0d", pop_count, sel_res_data, e);
        end
      end
      pop_count++;
      last_pop_cyc = cyc;
    end
    if ((dut_a.push && dut_a.fifo_count == 3'd4) || (dut_b.push && dut_b.fifo_count == 3'd4) ||
        (dut_c.push && dut_c.fifo_count == 3'd4)) begin
      checks++; errors++;
      $display("FAIL push_while_full got push required no push");
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      64'(sel_busy), 64'd0);
    check({tag, "_done"},      64'(sel_done), 64'd0);
    check({tag, "_pix_ready"}, 64'(sel_pix_ready), 64'd0);
    check({tag, "_res_valid"}, 64'(sel_res_valid), 64'd0);
    check({tag, "_res_data"},  64'(sel_res_data), 64'd0);
    check({tag, "_conv_data"}, 64'(sel_cd), 64'd0);
    check({tag, "_conv_kern"}, 64'(sel_ck), 64'd0);
  endtask

  // Reference: every full 3x3 neighbourhood of the image, raster order.
  task automatic push_expected(input int w, input int h);
    for (int y = 2; y < h; y++)
      for (int x = 2; x < w; x++) begin
        int acc = 0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            acc += int'(img[(y - 2 + r) * w + (x - 2 + c)]) * int'(kernel[r][c]);
        exp_q.push_back(12'(acc));
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic begin_frame(input int w, input int h, input string tag);
    push_expected(w, h);
    pop_count = 0;
    frame_n = (w - 2) * (h - 2);
    k_saved = kernel;
    pulse_start();
    @(negedge clk);
    check({tag, "_busy_after_start"}, 64'(sel_busy), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_pixel(input logic [3:0] d, input int gap_pct, input int max_wait, output bit ok);
    int n = 0;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      pix_valid = 1'b0;
      @(posedge clk); #1;
    end
    pix_valid = 1'b1;
    pix_data = d;
    ok = 1'b0;
    while (!ok && n < max_wait) begin
      @(negedge clk);
      ok = sel_pix_ready;
      @(posedge clk); #1;
      n++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input int gap_pct);
    bit ok;
    for (int p = first; p <= last; p++) begin
      send_pixel(img[p], gap_pct, 3000, ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL pixel_accept_timeout got stalled at pixel %0d required accept", p);
        break;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      seen = sel_done;
      n++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_result_count"}, 64'(pop_count), 64'(frame_n));
    check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_done_after_pop"}, 64'((cyc - last_pop_cyc >= 1) && (cyc - last_pop_cyc <= 2)), 64'd1);
    check({tag, "_kernel_held"}, 64'(sel_ck), 64'(k_saved));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'({sel_done, sel_busy}), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    int accepted;
    rst_n = 1'b0; sel = 0; start = 1'b0; kernel = '0;
    pix_valid = 1'b0; pix_data = '0; res_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k; #1;
      check_reset_outputs($sformatf("reset_dut%0d", k));
    end
    sel = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 4x4 all ones, kernel all ones: four 9s.
    for (int i = 0; i < 16; i++) img[i] = 4'd1;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) kernel[r][c] = 4'd1;
    check("model_ones", 64'(exp_q.size()), 64'd0);
    begin_frame(4, 4, "ones");
    feed(0, 15, 0);
    wait_done("ones");

    // 4x4 ramp, centre tap only; i_start and a new kernel mid-frame are ignored.
    for (int i = 0; i < 16; i++) img[i] = 4'(i);
    kernel = '0; kernel[1][1] = 4'd1;
    begin_frame(4, 4, "ramp");
    feed(0, 5, 0);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) kernel[r][c] = 4'($urandom);
    pulse_start();
    feed(6, 15, 0);
    wait_done("ramp");

    // 4x4 saturated: 2025 each, no truncation.
    for (int i = 0; i < 16; i++) img[i] = 4'd15;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) kernel[r][c] = 4'd15;
    begin_frame(4, 4, "max");
    feed(0, 15, 0);
    wait_done("max");

    // 8x8 with consumer held off: four credits admit pixels 0..21 only.
    sel = 1; res_mode = 1;
    for (int i = 0; i < 64; i++) img[i] = 4'($urandom);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) kernel[r][c] = 4'($urandom);
    begin_frame(8, 8, "credit");
    accepted = 0;
    for (int p = 0; p < 64; p++) begin
      send_pixel(img[p], 0, 20, ok);
      if (!ok) break;
      accepted++;
    end
    check("credit_stall_pixels", 64'(accepted), 64'd22);
    @(negedge clk);
    check("credit_pix_ready_low", 64'(sel_pix_ready), 64'd0);
    check("credit_res_valid", 64'(sel_res_valid), 64'd1);
    @(posedge clk); #1;
    res_mode = 0;
    feed(accepted, 63, 0);
    wait_done("credit");

    // Reset after ten pixels aborts the frame; a fresh frame then runs clean.
    for (int i = 0; i < 64; i++) img[i] = 4'($urandom);
    begin_frame(8, 8, "abort");
    feed(0, 9, 0);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_mode = 2;
    for (int i = 0; i < 64; i++) img[i] = 4'($urandom);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) kernel[r][c] = 4'($urandom);
    begin_frame(8, 8, "fresh");
    feed(0, 63, 30);
    wait_done("fresh");

    // 5x3 with random gaps on both sides: exactly three results.
    sel = 2;
    for (int i = 0; i < 15; i++) img[i] = 4'($urandom);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) kernel[r][c] = 4'($urandom);
    begin_frame(5, 3, "gaps");
    feed(0, 14, 40);
    wait_done("gaps");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
